// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 scan-code receiver
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  // Device status/ack bytes that never describe a key
  localparam logic [7:0] PS2_DROP_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_DROP_BAT   = 8'hAA;
  localparam logic [7:0] PS2_DROP_ACK   = 8'hFA;
  localparam logic [7:0] PS2_DROP_RSND  = 8'hFE;
  localparam logic [7:0] PS2_DROP_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_DROP_OVR0  = 8'h00;
  localparam logic [7:0] PS2_DROP_OVR1  = 8'hFF;

  localparam int KEY_TOGGLE = 10;
  localparam int KEY_REL    = 9;
  localparam int KEY_EXT    = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic is_dropped(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    case (b)
      PS2_DROP_PAUSE, PS2_DROP_BAT, PS2_DROP_ACK, PS2_DROP_RSND,
      PS2_DROP_ECHO, PS2_DROP_OVR0, PS2_DROP_OVR1: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line conditioning and 11-bit frame deframer
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          clk_s;
  logic          data_s;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall_stb;

  rx_state_t     state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par_ok, par_ok_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          valid_nxt;
  logic          err_nxt;

  // Synchronisers idle high so reset never looks like a clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
        fall_stb <= ~clk_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_ok     <= par_ok_nxt;
      to_cnt     <= to_cnt_nxt;
      byte_valid <= valid_nxt;
      frame_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_ok_nxt  = par_ok;
    to_cnt_nxt  = to_cnt;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    if (fall_stb) begin
      to_cnt_nxt = '0;
      case (state)
        RX_IDLE: begin
          if (data_s) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt   = RX_DATA;
            bit_cnt_nxt = '0;
          end
        end
        RX_DATA: begin
          shreg_nxt   = {data_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_nxt = ^{shreg, data_s};
          state_nxt  = RX_STOP;
        end
        RX_STOP: begin
          state_nxt = RX_IDLE;
          if (data_s && par_ok) valid_nxt = 1'b1;
          else                  err_nxt   = 1'b1;
        end
        default: state_nxt = RX_IDLE;
      endcase
    end else if (state != RX_IDLE) begin
      // A stalled partial frame is abandoned silently
      if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nxt  = RX_IDLE;
        to_cnt_nxt = '0;
      end else begin
        to_cnt_nxt = to_cnt + 1'b1;
      end
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_scancode.sv
// rtl/ps2_scancode.sv - PS/2 prefix tracking and toggling key event register
module ps2_scancode
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       ext_q;
  logic       rel_q;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // A framing error drops any pending prefixes so no event is misclassified
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_key <= '0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else if (frame_err) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_q <= 1'b1;
      end else if (rx_byte == PS2_REL) begin
        rel_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
        if (!is_dropped(rx_byte)) begin
          ps2_key[KEY_TOGGLE] <= ~ps2_key[KEY_TOGGLE];
          ps2_key[KEY_REL]    <= rel_q;
          ps2_key[KEY_EXT]    <= ext_q;
          ps2_key[7:0]        <= rx_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode.sv
// tb/tb_ps2_scancode.sv - self-checking bench for ps2_scancode
module tb_ps2_scancode;

  localparam int FILT = 8;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int          vectors       = 0;
  int          miscompares   = 0;
  int          cyc           = 0;
  int          last_stop_cyc = 0;
  int          exp_err       = 0;
  logic [10:0] m_key         = '0;
  logic [10:0] last_key      = '0;
  logic [10:0] cmp_e;
  logic        m_ext         = 1'b0;
  logic        m_rel         = 1'b0;
  logic        prev_err      = 1'b0;
  logic [10:0] exp_q[$];

  ps2_scancode #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_key = '0;
      prev_err = 1'b0;
    end else begin
      if (ps2_key !== last_key) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL event_unexpected: got %h, want no change from %h", ps2_key, last_key);
        end else begin
          cmp_e = exp_q.pop_front();
          if (ps2_key !== cmp_e) begin
            miscompares++;
            $display("FAIL event_value: got %h, want %h", ps2_key, cmp_e);
          end
        end
        vectors++;
        if (cyc - last_stop_cyc < FILT || cyc - last_stop_cyc > FILT + 6) begin
          miscompares++;
          $display("FAIL event_latency: got %0d cycles after stop edge, want %0d..%0d",
                   cyc - last_stop_cyc, FILT, FILT + 6);
        end
        last_key = ps2_key;
      end
      if (frame_err !== 1'b0) begin
        vectors++;
        if (exp_err == 0) begin
          miscompares++;
          $display("FAIL frame_err_unexpected: got %b, want 0", frame_err);
        end else begin
          exp_err--;
        end
        vectors++;
        if (prev_err) begin
          miscompares++;
          $display("FAIL frame_err_width: got 2+ cycle pulse, want 1 cycle");
        end
      end
      prev_err = frame_err;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic d);
    ps2_data = d;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    last_stop_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      m_key = {~m_key[10], m_rel, m_ext, b};
      exp_q.push_back(m_key);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop bit
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic [10:0] bits;
    logic        par;
    logic        stp;
    par  = (^b) ? 1'b0 : 1'b1;
    if (kind == 1) par = ~par;
    stp  = (kind == 2) ? 1'b0 : 1'b1;
    bits = {stp, par, b, 1'b0};
    model_frame(b, kind == 0);
    for (int i = 0; i < 11; i++) clk_bit(bits[i]);
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) clk_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
  endtask

  task automatic start_err();
    model_frame(8'h00, 1'b0);
    clk_bit(1'b1);
    wait_cyc(30);
  endtask

  task automatic glitch(input int len);
    ps2_clk = 1'b0;
    wait_cyc(len);
    ps2_clk = 1'b1;
    wait_cyc(20);
  endtask

  task automatic check_key(input string name, input logic [10:0] want);
    vectors++;
    if (ps2_key !== want) begin
      miscompares++;
      $display("FAIL %s: got ps2_key %h, want %h", name, ps2_key, want);
    end
    vectors++;
    if (m_key !== want) begin
      miscompares++;
      $display("FAIL %s_model: got model key %h, want %h", name, m_key, want);
    end
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (exp_q.size() != 0 || exp_err != 0 || ps2_key !== m_key) begin
      miscompares++;
      $display("FAIL %s: got key %h pending %0d/%0d, want key %h pending 0/0",
               name, ps2_key, exp_q.size(), exp_err, m_key);
    end
  endtask

  initial begin
    int r;
    int kind;
    logic [7:0] b;
    logic [7:0] drops [7];
    drops = '{8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    wait_cyc(4);
    vectors++;
    if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got key %h err %b, want 000 0", ps2_key, frame_err);
    end
    reset = 1'b0;
    wait_cyc(5);

    send_frame(8'h16, 0); check_key("make_16", 11'h416);
    send_frame(8'hF0, 0); send_frame(8'h16, 0); check_key("break_16", 11'h216);
    send_frame(8'h16, 0); check_key("remake_16", 11'h416);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    check_key("ext_break_75", 11'h375);
    send_frame(8'hE0, 0); send_frame(8'h75, 0); check_key("ext_make_75", 11'h575);
    send_frame(8'h69, 1); check_key("bad_parity_hold", 11'h575);
    send_frame(8'hE0, 0); send_frame(8'h69, 1); send_frame(8'h74, 0);
    check_key("err_clears_ext", 11'h074);
    send_frame(8'hF0, 0); send_frame(8'h12, 2); send_frame(8'h1C, 0);
    check_key("bad_stop_clears_rel", 11'h41C);

    send_partial(5);
    wait_cyc(TMO + 10);
    send_frame(8'h45, 0); check_key("after_timeout", 11'h045);

    for (int i = 0; i < 3; i++) glitch(3);
    check_key("glitch_ignored", 11'h045);

    send_frame(8'hE0, 0); start_err(); send_frame(8'h6B, 0);
    check_key("start_err_clears", 11'h46B);
    send_frame(8'hE0, 0); send_frame(8'hAA, 0); send_frame(8'h6B, 0);
    check_key("dropped_clears", 11'h06B);
    check_idle("directed_done");

    send_frame(8'hE0, 0);
    send_partial(5);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    m_key = '0; m_ext = 1'b0; m_rel = 1'b0; exp_err = 0;
    exp_q.delete();
    check_key("mid_frame_reset", 11'h000);
    wait_cyc(5);
    send_frame(8'h7C, 0); check_key("after_reset_7C", 11'h47C);

    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 1)      b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r == 3) b = drops[$urandom_range(0, 6)];
      else             b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 15);
      kind = (r < 2) ? 1 : (r == 2) ? 2 : 0;
      send_frame(b, kind);
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, FILT - 3));
      if (n % 10 == 9) check_idle("random_block");
    end

    wait_cyc(50);
    check_idle("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
